// File: rtl/decoder_bank_1_2_4_16.sv
// rtl/decoder_bank_1_2_4_16.sv - registered 1-to-2, 4-to-16 and cascaded 5-to-32 one-hot decoder bank

// 1-to-2 one-hot decoder; a disabled decoder drives zeros whatever the select holds
module dec1_2 (
    input  logic       a,
    input  logic       en,
    output logic [1:0] y
);

    // AND-gating with en keeps the output zero even when a is unknown
    always_comb begin
        y    = 2'b00;
        y[0] = en & ~a;
        y[1] = en & a;
    end

endmodule

// 4-to-16 one-hot decoder; a disabled decoder drives zeros whatever the select holds
module dec4_16 (
    input  logic [3:0]  a,
    input  logic        en,
    output logic [15:0] y
);

    // only a set enable lets the shifted one reach the output
    always_comb begin
        y = 16'h0000;
        if (en) begin
            y = 16'h0001 << a;
        end
    end

endmodule

// Decoder bank feeding register-file write enables
module decoder_bank_1_2_4_16 #(
    parameter int REG_OUT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a1,
    input  logic        en1,
    input  logic [3:0]  a4,
    input  logic        en4,
    input  logic [4:0]  a5,
    input  logic        en5,
    output logic [1:0]  out2,
    output logic [15:0] out16,
    output logic [31:0] out32,
    output logic        valid
);

    logic [1:0]  out2_d;
    logic [15:0] out16_d;
    logic [31:0] out32_d;
    logic [1:0]  sel5;
    logic        valid_d;
    logic        valid_q;

    dec1_2 u_dec1_2 (
        .a  (a1),
        .en (en1),
        .y  (out2_d)
    );

    dec4_16 u_dec4_16 (
        .a  (a4),
        .en (en4),
        .y  (out16_d)
    );

    // a5[4] picks which 16-bit half of the cascaded output is enabled
    dec1_2 u_dec5_sel (
        .a  (a5[4]),
        .en (en5),
        .y  (sel5)
    );

    dec4_16 u_dec5_lo (
        .a  (a5[3:0]),
        .en (sel5[0]),
        .y  (out32_d[15:0])
    );

    dec4_16 u_dec5_hi (
        .a  (a5[3:0]),
        .en (sel5[1]),
        .y  (out32_d[31:16])
    );

    // valid rises on the first edge after reset release and stays high
    always_comb begin
        valid_d = 1'b1;
    end

    // valid flag register, cleared asynchronously in both output modes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid = valid_q;

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [1:0]  out2_q;
            logic [15:0] out16_q;
            logic [31:0] out32_q;

            // all decode results are captured together so every output moves on the same edge
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out2_q  <= 2'b00;
                    out16_q <= 16'h0000;
                    out32_q <= 32'h0000_0000;
                end else begin
                    out2_q  <= out2_d;
                    out16_q <= out16_d;
                    out32_q <= out32_d;
                end
            end

            assign out2  = out2_q;
            assign out16 = out16_q;
            assign out32 = out32_q;
        end else begin : g_comb
            // reset still forces every select low while it is held
            assign out2  = rst_n ? out2_d  : 2'b00;
            assign out16 = rst_n ? out16_d : 16'h0000;
            assign out32 = rst_n ? out32_d : 32'h0000_0000;
        end
    endgenerate

endmodule

// File: tb/tb_decoder_bank_1_2_4_16.sv
// tb/tb_decoder_bank_1_2_4_16.sv - directed-vector bench for decoder_bank_1_2_4_16
module tb_decoder_bank_1_2_4_16;

    logic        clk;
    logic        rst_n;
    logic        a1;
    logic        en1;
    logic [3:0]  a4;
    logic        en4;
    logic [4:0]  a5;
    logic        en5;
    logic [1:0]  out2;
    logic [15:0] out16;
    logic [31:0] out32;
    logic        valid;
    logic [1:0]  out2_c;
    logic [15:0] out16_c;
    logic [31:0] out32_c;
    logic        valid_c;

    int n_vec;
    int n_miscompare;
    bit running;

    decoder_bank_1_2_4_16 #(.REG_OUT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a1    (a1),
        .en1   (en1),
        .a4    (a4),
        .en4   (en4),
        .a5    (a5),
        .en5   (en5),
        .out2  (out2),
        .out16 (out16),
        .out32 (out32),
        .valid (valid)
    );

    decoder_bank_1_2_4_16 #(.REG_OUT(0)) dut_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .a1    (a1),
        .en1   (en1),
        .a4    (a4),
        .en4   (en4),
        .a5    (a5),
        .en5   (en5),
        .out2  (out2_c),
        .out16 (out16_c),
        .out32 (out32_c),
        .valid (valid_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one-hot invariant on every registered output, sampled away from the edge
    always @(negedge clk) begin
        if (running) begin
            check_val("pop2",  32'($countones(out2)  <= 1), 32'd1);
            check_val("pop16", 32'($countones(out16) <= 1), 32'd1);
            check_val("pop32", 32'($countones(out32) <= 1), 32'd1);
        end
    end

    initial begin
        n_vec        = 0;
        n_miscompare = 0;
        running      = 1'b0;
        rst_n = 1'b0;
        a1 = 1'b0; en1 = 1'b1;
        a4 = 4'd0; en4 = 1'b1;
        a5 = 5'd7; en5 = 1'b1;

        // reset wins over enables, no clock edge yet
        #3;
        check_val("rst_out2",  {30'd0, out2},  32'h0);
        check_val("rst_out16", {16'd0, out16}, 32'h0);
        check_val("rst_out32", out32,          32'h0);
        check_val("rst_valid", {31'd0, valid}, 32'h0);
        check_val("rst_comb32", out32_c,       32'h0);
        step();
        check_val("rst_hold32", out32, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rel_noedge32", out32, 32'h0);
        check_val("rel_comb32", out32_c, 32'h0000_0080);
        step();
        check_val("rel_out32", out32,          32'h0000_0080);
        check_val("rel_valid", {31'd0, valid}, 32'h1);
        check_val("rel_out2",  {30'd0, out2},  32'h1);
        check_val("rel_out16", {16'd0, out16}, 32'h1);
        running = 1'b1;

        // disabled sweeps
        en1 = 1'b0; en4 = 1'b0; en5 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a5 = 5'(i);
            a4 = 4'(i);
            a1 = i[0];
            step();
            check_val("dis_out32", out32,          32'h0);
            check_val("dis_out16", {16'd0, out16}, 32'h0);
            check_val("dis_out2",  {30'd0, out2},  32'h0);
        end

        // enabled cascaded sweep with hand-computed spot checks
        en5 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a5 = 5'(i);
            step();
            check_val("en_out32", out32, 32'h1 << i);
            if (i == 0)  check_val("spot_a5_0",  out32, 32'h0000_0001);
            if (i == 15) check_val("spot_a5_15", out32, 32'h0000_8000);
            if (i == 16) check_val("spot_a5_16", out32, 32'h0001_0000);
            if (i == 31) check_val("spot_a5_31", out32, 32'h8000_0000);
        end

        // standalone decoders
        en1 = 1'b1; a1 = 1'b0; step();
        check_val("out2_a0", {30'd0, out2}, 32'h1);
        a1 = 1'b1; step();
        check_val("out2_a1", {30'd0, out2}, 32'h2);
        en4 = 1'b1; a4 = 4'hA; step();
        check_val("out16_aA", {16'd0, out16}, 32'h0400);
        a4 = 4'hF; step();
        check_val("out16_aF", {16'd0, out16}, 32'h8000);

        // combinational mode follows inputs without an edge
        a4 = 4'h5;
        #1;
        check_val("comb_out16", {16'd0, out16_c}, 32'h0020);
        check_val("reg_hold16", {16'd0, out16},   32'h8000);

        // latency: enable drop between edges is invisible until the next edge
        a4 = 4'd3; step();
        check_val("lat_out16", {16'd0, out16}, 32'h0008);
        en4 = 1'b0;
        #3;
        check_val("lat_hold16", {16'd0, out16}, 32'h0008);
        step();
        check_val("lat_off16", {16'd0, out16}, 32'h0);

        // unknown select while disabled
        a4 = 4'bxxxx; step();
        check_val("x_dis16", {16'd0, out16}, 32'h0);
        a4 = 4'd0;

        // mid-operation reset pulse
        en5 = 1'b1; a5 = 5'd16; step();
        check_val("mid_pre32", out32, 32'h0001_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst32",   out32,          32'h0);
        check_val("mid_rstval",  {31'd0, valid}, 32'h0);
        #3;
        rst_n = 1'b1;
        #1;
        check_val("mid_rel32", out32, 32'h0);
        step();
        check_val("mid_edge32", out32,          32'h0001_0000);
        check_val("mid_valid",  {31'd0, valid}, 32'h1);

        running = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
